// File: rtl/stat_update_scheduler_pkg.sv
// ============================================================================
// stat_update_scheduler_pkg : stat indices, state encoding, decay target map
// Revision 1.0
// ============================================================================
`default_nettype none

package stat_update_scheduler_pkg;

   localparam logic [2:0] STAT_HUNGER    = 3'd0;
   localparam logic [2:0] STAT_HAPPINESS = 3'd1;
   localparam logic [2:0] STAT_HEALTH    = 3'd2;
   localparam logic [2:0] STAT_HYGIENE   = 3'd3;
   localparam logic [2:0] STAT_ENERGY    = 3'd4;
   localparam logic [2:0] STAT_SOCIAL    = 3'd5;
   localparam int         NUM_STATS      = 6;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_COOL  = 2'd2
   } state_t;

   // Folds a 3-bit random value onto the six stats (6 -> 0, 7 -> 1).
   function automatic logic [2:0] decay_stat(input logic [3:0] rnd);
      return (rnd[2:0] < 3'd6) ? rnd[2:0] : rnd[2:0] - 3'd6;
   endfunction

endpackage

`default_nettype wire

// File: rtl/stat_update_scheduler_if.sv
// ============================================================================
// stat_update_scheduler_if : valid/ready update-op channel to the stats block
// Revision 1.0
// ============================================================================
`default_nettype none

interface stat_update_scheduler_if;
   logic       op_valid;
   logic       op_ready;
   logic [2:0] op_stat;
   logic       op_inc;
   logic [3:0] op_amt;

   modport master (output op_valid, output op_stat, output op_inc, output op_amt,
                   input  op_ready);
   modport slave  (input  op_valid, input  op_stat, input  op_inc, input  op_amt,
                   output op_ready);
endinterface

`default_nettype wire

// File: rtl/stat_update_scheduler_rr_arbiter6.sv
// ============================================================================
// rr_arbiter6 : combinational 6-way round-robin pick starting at ptr
// Revision 1.0
// ============================================================================
`default_nettype none

module rr_arbiter6
   import stat_update_scheduler_pkg::*;
(
   input  logic [5:0] req,
   input  logic [2:0] ptr,
   output logic [5:0] gnt,
   output logic [2:0] idx
);

   logic [3:0] cand;
   logic       found;

   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      cand  = '0;
      for (int k = 0; k < NUM_STATS; k++) begin
         cand = {1'b0, ptr} + 4'(k);
         if (cand >= 4'(NUM_STATS)) begin
            cand = cand - 4'(NUM_STATS);
         end
         if (!found && req[cand[2:0]]) begin
            found            = 1'b1;
            gnt[cand[2:0]]   = 1'b1;
            idx              = cand[2:0];
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/stat_update_scheduler.sv
// ============================================================================
// stat_update_scheduler : serialises button and decay updates to the stats block
// Revision 1.0
// ============================================================================
`default_nettype none

module stat_update_scheduler
   import stat_update_scheduler_pkg::*;
#(
   parameter logic [23:0] MAX_COUNT = 24'd10_000_000,
   parameter logic [7:0]  COOLDOWN  = 8'd16,
   parameter logic [3:0]  ACT_AMT   = 4'd3
)(
   input  logic                           clk,
   input  logic                           reset,
   input  logic [5:0]                     act_req,
   input  logic [3:0]                     random,
   stat_update_scheduler_if.master        op,
   output logic [6:0]                     grant,
   output logic                           busy,
   output logic                           tick
);

   logic [5:0]  act_q;
   logic [5:0]  act_pend;
   logic [5:0]  act_rise;
   logic [5:0]  act_clr;
   logic [23:0] dec_cnt;
   logic        dec_pend;
   logic        dec_wrap;
   logic        dec_clr;
   logic        handshake;

   state_t      state;
   logic [7:0]  cool_cnt;
   logic [2:0]  rr_ptr;
   logic        valid_r;
   logic [2:0]  stat_r;
   logic        inc_r;
   logic [3:0]  amt_r;

   logic [5:0]  arb_gnt;
   logic [2:0]  arb_idx;

   assign act_rise  = act_req & ~act_q;
   assign handshake = valid_r & op.op_ready;
   assign act_clr   = handshake ? grant[5:0] : 6'd0;
   assign dec_clr   = handshake & grant[6];
   assign dec_wrap  = (dec_cnt == MAX_COUNT - 24'd1);

   assign op.op_valid = valid_r;
   assign op.op_stat  = stat_r;
   assign op.op_inc   = inc_r;
   assign op.op_amt   = amt_r;

   rr_arbiter6 u_arb (
      .req (act_pend),
      .ptr (rr_ptr),
      .gnt (arb_gnt),
      .idx (arb_idx)
   );

   // A new edge on the clearing cycle re-arms the flag (set wins).
   always_ff @(posedge clk) begin
      if (reset) begin
         act_q    <= '0;
         act_pend <= '0;
      end else begin
         act_q    <= act_req;
         act_pend <= (act_pend & ~act_clr) | act_rise;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         dec_cnt  <= '0;
         tick     <= 1'b0;
         dec_pend <= 1'b0;
      end else begin
         dec_cnt  <= dec_wrap ? 24'd0 : dec_cnt + 24'd1;
         tick     <= dec_wrap;
         dec_pend <= (dec_pend & ~dec_clr) | dec_wrap;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         cool_cnt <= '0;
         rr_ptr   <= '0;
         valid_r  <= 1'b0;
         stat_r   <= '0;
         inc_r    <= 1'b0;
         amt_r    <= '0;
         grant    <= '0;
         busy     <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (dec_pend) begin
                  state   <= S_ISSUE;
                  busy    <= 1'b1;
                  valid_r <= 1'b1;
                  grant   <= 7'b100_0000;
                  stat_r  <= decay_stat(random);
                  inc_r   <= 1'b0;
                  amt_r   <= 4'd1;
               end else if (|act_pend) begin
                  state   <= S_ISSUE;
                  busy    <= 1'b1;
                  valid_r <= 1'b1;
                  grant   <= {1'b0, arb_gnt};
                  stat_r  <= arb_idx;
                  inc_r   <= 1'b1;
                  amt_r   <= ACT_AMT;
               end
            end
            S_ISSUE: begin
               if (op.op_ready) begin
                  if (!grant[6]) begin
                     rr_ptr <= (stat_r == STAT_SOCIAL) ? STAT_HUNGER : stat_r + 3'd1;
                  end
                  state    <= S_COOL;
                  cool_cnt <= COOLDOWN - 8'd1;
                  valid_r  <= 1'b0;
                  grant    <= '0;
                  stat_r   <= '0;
                  inc_r    <= 1'b0;
                  amt_r    <= '0;
               end
            end
            S_COOL: begin
               if (cool_cnt == 8'd0) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end else begin
                  cool_cnt <= cool_cnt - 8'd1;
               end
            end
            default: begin
               state   <= S_IDLE;
               busy    <= 1'b0;
               valid_r <= 1'b0;
               grant   <= '0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_stat_update_scheduler.sv
// ============================================================================
// tb_stat_update_scheduler : directed table, corner sequences, random vs model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_stat_update_scheduler;

   localparam int MAXC  = 20;
   localparam int COOLN = 4;
   localparam int ACTA  = 3;

   logic       clk     = 1'b0;
   logic       reset   = 1'b1;
   logic [5:0] act_req = '0;
   logic [3:0] random  = '0;
   logic [6:0] grant;
   logic       busy;
   logic       tick;

   stat_update_scheduler_if op_if ();

   stat_update_scheduler #(
      .MAX_COUNT (24'd20),
      .COOLDOWN  (8'd4),
      .ACT_AMT   (4'd3)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .act_req (act_req),
      .random  (random),
      .op      (op_if),
      .grant   (grant),
      .busy    (busy),
      .tick    (tick)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int edges  = 0;
   int log_grant[$];
   int log_stat[$];

   // Behavioural model: pending sets, owner id (-1 none, 0..5 action, 6 decay), cooldown left
   bit [5:0] m_prev, m_apend;
   bit       m_dpend, m_tick, m_valid, m_inc;
   int       m_cnt, m_owner = -1, m_stat, m_amt, m_cool, m_rr;

   task automatic chk(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic model_step(input bit r, input bit [5:0] a, input bit [3:0] rn, input bit rdy);
      bit [5:0] n_apend;
      bit       n_dpend, hs, wrap, found;
      int       i;
      if (r) begin
         m_prev = '0; m_apend = '0; m_dpend = 0; m_tick = 0; m_valid = 0; m_inc = 0;
         m_cnt = 0; m_owner = -1; m_stat = 0; m_amt = 0; m_cool = 0; m_rr = 0;
         return;
      end
      hs   = m_valid && rdy;
      wrap = (m_cnt == MAXC - 1);
      n_apend = a & ~m_prev;
      for (int s = 0; s < 6; s++)
         if (m_apend[s] && !(hs && m_owner == s)) n_apend[s] = 1'b1;
      n_dpend = wrap || (m_dpend && !(hs && m_owner == 6));
      if (m_valid) begin
         if (rdy) begin
            if (m_owner < 6) m_rr = (m_owner + 1) % 6;
            m_valid = 0; m_owner = -1; m_cool = COOLN; m_stat = 0; m_inc = 0; m_amt = 0;
         end
      end else if (m_cool > 0) begin
         m_cool--;
      end else if (m_dpend) begin
         m_valid = 1; m_owner = 6; m_stat = int'(rn[2:0]) % 6; m_inc = 0; m_amt = 1;
      end else begin
         found = 0;
         for (int k = 0; k < 6; k++) begin
            i = (m_rr + k) % 6;
            if (!found && m_apend[i]) begin
               found = 1; m_valid = 1; m_owner = i; m_stat = i; m_inc = 1; m_amt = ACTA;
            end
         end
      end
      m_apend = n_apend;
      m_dpend = n_dpend;
      m_cnt   = wrap ? 0 : m_cnt + 1;
      m_tick  = wrap;
      m_prev  = a;
   endtask

   // Called on the falling edge: drive inputs, cross one rising edge, compare against the model.
   task automatic step(input bit r, input bit [5:0] a, input bit [3:0] rn, input bit rdy);
      reset = r; act_req = a; random = rn; op_if.op_ready = rdy;
      if (op_if.op_valid && rdy) begin
         log_grant.push_back(int'(grant));
         log_stat.push_back(int'(op_if.op_stat));
      end
      @(posedge clk);
      @(negedge clk);
      if (r) edges = 0; else edges++;
      model_step(r, a, rn, rdy);
      chk("m_valid", int'(op_if.op_valid), int'(m_valid));
      chk("m_stat",  int'(op_if.op_stat),  m_stat);
      chk("m_inc",   int'(op_if.op_inc),   int'(m_inc));
      chk("m_amt",   int'(op_if.op_amt),   m_amt);
      chk("m_grant", int'(grant),          (m_owner < 0) ? 0 : (1 << m_owner));
      chk("m_busy",  int'(busy),           int'(m_valid || m_cool > 0));
      chk("m_tick",  int'(tick),           int'(m_tick));
   endtask

   typedef struct {
      bit       rst;
      bit [5:0] act;
      bit       valid;
      bit [2:0] stat;
      bit       inc;
      bit [3:0] amt;
      bit [6:0] grant;
      bit       busy;
   } vec_t;

   vec_t vt[10];
   int   n_dec, n_act;
   int   act_stats[$];

   initial begin
      #500000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1);
   end

   initial begin
      op_if.op_ready = 1'b1;
      // reset x3, single-cycle press of button 0, issue, 4 cooldown cycles, idle
      vt[0] = '{1'b1, 6'd0, 1'b0, 3'd0, 1'b0, 4'd0, 7'd0, 1'b0};
      vt[1] = '{1'b1, 6'd0, 1'b0, 3'd0, 1'b0, 4'd0, 7'd0, 1'b0};
      vt[2] = '{1'b1, 6'd0, 1'b0, 3'd0, 1'b0, 4'd0, 7'd0, 1'b0};
      vt[3] = '{1'b0, 6'd1, 1'b0, 3'd0, 1'b0, 4'd0, 7'd0, 1'b0};
      vt[4] = '{1'b0, 6'd0, 1'b1, 3'd0, 1'b1, 4'd3, 7'd1, 1'b1};
      vt[5] = '{1'b0, 6'd0, 1'b0, 3'd0, 1'b0, 4'd0, 7'd0, 1'b1};
      vt[6] = '{1'b0, 6'd0, 1'b0, 3'd0, 1'b0, 4'd0, 7'd0, 1'b1};
      vt[7] = '{1'b0, 6'd0, 1'b0, 3'd0, 1'b0, 4'd0, 7'd0, 1'b1};
      vt[8] = '{1'b0, 6'd0, 1'b0, 3'd0, 1'b0, 4'd0, 7'd0, 1'b1};
      vt[9] = '{1'b0, 6'd0, 1'b0, 3'd0, 1'b0, 4'd0, 7'd0, 1'b0};
      @(negedge clk);
      for (int r = 0; r < 10; r++) begin
         step(vt[r].rst, vt[r].act, 4'd0, 1'b1);
         chk($sformatf("vec%0d_valid", r), int'(op_if.op_valid), int'(vt[r].valid));
         chk($sformatf("vec%0d_stat", r),  int'(op_if.op_stat),  int'(vt[r].stat));
         chk($sformatf("vec%0d_inc", r),   int'(op_if.op_inc),   int'(vt[r].inc));
         chk($sformatf("vec%0d_amt", r),   int'(op_if.op_amt),   int'(vt[r].amt));
         chk($sformatf("vec%0d_grant", r), int'(grant),          int'(vt[r].grant));
         chk($sformatf("vec%0d_busy", r),  int'(busy),           int'(vt[r].busy));
         chk($sformatf("vec%0d_tick", r),  int'(tick),           0);
      end

      // First tick lands 20 edges after reset release; decay op uses random=7 -> stat 1
      for (int i = 0; i < 40 && !tick; i++) step(1'b0, 6'd0, 4'b0111, 1'b1);
      chk("first_tick_edge", edges, 20);
      chk("first_tick_seen", int'(tick), 1);
      step(1'b0, 6'd0, 4'b0111, 1'b1);
      chk("dec_valid", int'(op_if.op_valid), 1);
      chk("dec_stat",  int'(op_if.op_stat),  1);
      chk("dec_inc",   int'(op_if.op_inc),   0);
      chk("dec_amt",   int'(op_if.op_amt),   1);
      chk("dec_grant", int'(grant),          64);
      chk("tick_width", int'(tick),          0);

      // Held buttons 2 and 5: exactly one op each, stat 2 first
      for (int i = 0; i < 20 && busy; i++) step(1'b0, 6'd0, 4'd0, 1'b1);
      log_grant.delete(); log_stat.delete();
      for (int i = 0; i < 40; i++) step(1'b0, 6'b100100, 4'd0, 1'b1);
      act_stats.delete();
      foreach (log_grant[k]) if (log_grant[k] != 64) act_stats.push_back(log_stat[k]);
      chk("held_count", act_stats.size(), 2);
      if (act_stats.size() >= 2) begin
         chk("held_first",  act_stats[0], 2);
         chk("held_second", act_stats[1], 5);
      end

      // Tick and button-3 edge in the same idle cycle: decay wins
      for (int i = 0; i < 200 && !(!busy && m_cnt == 18 && !m_dpend && m_apend == 0 && !m_valid); i++)
         step(1'b0, 6'd0, 4'd0, 1'b1);
      chk("align_idle", int'(busy), 0);
      step(1'b0, 6'd0, 4'b0110, 1'b1);
      step(1'b0, 6'b001000, 4'b0110, 1'b1);
      log_grant.delete(); log_stat.delete();
      for (int i = 0; i < 12; i++) step(1'b0, 6'b001000, 4'b0110, 1'b1);
      chk("tie_ops", (log_grant.size() >= 2) ? 1 : 0, 1);
      if (log_grant.size() >= 2) begin
         chk("tie_first_grant",  log_grant[0], 64);
         chk("tie_first_stat",   log_stat[0],  0);
         chk("tie_second_grant", log_grant[1], 8);
         chk("tie_second_stat",  log_stat[1],  3);
      end

      // Stalled decay op spanning a second tick, which is dropped
      for (int i = 0; i < 60 && !op_if.op_valid; i++) step(1'b0, 6'd0, 4'b0101, 1'b0);
      chk("stall_start_grant", int'(grant), 64);
      for (int i = 0; i < 22; i++) begin
         step(1'b0, 6'd0, 4'd0, 1'b0);
         chk("stall_valid", int'(op_if.op_valid), 1);
         chk("stall_stat",  int'(op_if.op_stat),  5);
         chk("stall_grant", int'(grant),          64);
         chk("stall_amt",   int'(op_if.op_amt),   1);
      end
      log_grant.delete(); log_stat.delete();
      for (int i = 0; i < 14; i++) step(1'b0, 6'd0, 4'd0, 1'b1);
      n_dec = 0;
      foreach (log_grant[k]) if (log_grant[k] == 64) n_dec++;
      chk("stall_decay_ops", n_dec, 1);

      // Reset while an op is in ISSUE
      step(1'b0, 6'b100010, 4'd0, 1'b0);
      for (int i = 0; i < 10 && !op_if.op_valid; i++) step(1'b0, 6'd0, 4'd0, 1'b0);
      chk("rst_pre_valid", int'(op_if.op_valid), 1);
      step(1'b1, 6'd0, 4'd0, 1'b0);
      chk("rst_valid", int'(op_if.op_valid), 0);
      chk("rst_grant", int'(grant), 0);
      chk("rst_busy",  int'(busy), 0);
      n_act = 0;
      for (int i = 0; i < 12; i++) begin
         step(1'b0, 6'd0, 4'd0, 1'b1);
         if (op_if.op_valid) n_act++;
      end
      chk("rst_pend_lost", n_act, 0);

      // Random traffic against the model
      begin
         bit [5:0] a;
         a = '0;
         for (int i = 0; i < 700; i++) begin
            for (int b = 0; b < 6; b++) if ($urandom_range(0, 7) == 0) a[b] = ~a[b];
            step(($urandom_range(0, 299) == 0), a, 4'($urandom), ($urandom_range(0, 3) != 0));
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
